uart_host_bridge: RTL and testbench

Host-side end of the UART master/slave link. It turns local bus requests into protocol frames on the wire. Every frame byte has bit7=1; the payload is hex ASCII. It parses the remote's reply frames into read data, completion and error. Bytes with bit7=0 form a transparent stream channel in both directions. The block drives an existing uart_tx (i_start/o_ready) and consumes an existing uart_rx (o_received_pulse/o_dat).

---
 rtl/uart_host_bridge.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_uart_host_bridge.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_host_bridge.sv
// Host end of the UART master/slave link: bus requests become hex-ASCII frames (bit7=1),
// reply frames become read data / completion / error; bit7=0 bytes form a transparent stream.
module uart_host_bridge #(
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int CNT_W          = 22
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [15:0] i_addr,
   input  logic [7:0]  i_wdata,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [7:0]  o_rdata,
   input  logic        i_stream_push,
   input  logic [7:0]  i_stream_dat,
   output logic        o_stream_ready,
   output logic        o_stream_valid,
   output logic [7:0]  o_stream_dat,
   output logic        o_tx_start,
   output logic [7:0]  o_tx_dat,
   input  logic        i_tx_ready,
   input  logic        i_rx_pulse,
   input  logic [7:0]  i_rx_dat
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TX_CMD,
      S_TX_ADDR,
      S_TX_DATA,
      S_WAIT_RESP,
      S_RESP_LO,
      S_FINISH
   } state_t;

   localparam logic [7:0] LP_CMD_WR = 8'hD7;
   localparam logic [7:0] LP_CMD_RD = 8'hD2;
   localparam logic [7:0] LP_ACK    = 8'hCB;
   // FINISH and the registered o_done add two cycles after the timeout decision
   localparam logic [CNT_W-1:0] LP_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

   state_t r_state;
   state_t w_state_nxt;

   logic             r_we;
   logic [15:0]      r_addr;
   logic [7:0]       r_wdata;
   logic [2:0]       r_idx;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic [7:0]       r_rdata;
   logic [7:0]       r_sbuf;
   logic             r_sfull;
   logic             r_tx_start;
   logic [7:0]       r_tx_dat;
   logic [7:0]       r_srx_dat;
   logic             r_srx_valid;

   logic       w_tx_ok;
   logic       w_rx_proto;
   logic       w_rx_stream;
   logic [4:0] w_dec;
   logic       w_timeout;
   logic       w_frame_send;
   logic [7:0] w_frame_byte;
   logic       w_stream_send;
   logic [2:0] w_idx_nxt;
   logic       w_cnt_clr;
   logic       w_fin;
   logic       w_fin_err;
   logic       w_load_hi;
   logic       w_load_lo;
   logic [3:0] w_addr_nib;
   logic [3:0] w_data_nib;

   function automatic logic [7:0] f_enc(input logic [3:0] n);
      if (n < 4'd10) return 8'hB0 + {4'b0000, n};
      else           return 8'hD7 + {4'b0000, n};
   endfunction

   // returns {valid, nibble}
   function automatic logic [4:0] f_dec(input logic [7:0] b);
      logic [6:0] c;
      c = b[6:0];
      if (!b[7]) return 5'b0;
      if (c >= 7'h30 && c <= 7'h39) return {1'b1, b[3:0]};
      if ((c >= 7'h41 && c <= 7'h46) || (c >= 7'h61 && c <= 7'h66))
         return {1'b1, b[3:0] + 4'd9};
      return 5'b0;
   endfunction

   assign w_tx_ok     = i_tx_ready & ~r_tx_start;
   assign w_rx_proto  = i_rx_pulse & i_rx_dat[7];
   assign w_rx_stream = i_rx_pulse & ~i_rx_dat[7];
   assign w_dec       = f_dec(i_rx_dat);
   assign w_timeout   = (r_cnt >= LP_TO_LAST);

   always_comb begin
      w_addr_nib = r_addr[15:12];
      case (r_idx[1:0])
         2'd0:    w_addr_nib = r_addr[15:12];
         2'd1:    w_addr_nib = r_addr[11:8];
         2'd2:    w_addr_nib = r_addr[7:4];
         default: w_addr_nib = r_addr[3:0];
      endcase
      w_data_nib = r_idx[0] ? r_wdata[3:0] : r_wdata[7:4];
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_frame_send = 1'b0;
      w_frame_byte = '0;
      w_idx_nxt    = r_idx;
      w_cnt_clr    = 1'b0;
      w_fin_err    = 1'b0;
      w_load_hi    = 1'b0;
      w_load_lo    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_req) w_state_nxt = S_TX_CMD;
         end
         S_TX_CMD: begin
            w_frame_byte = r_we ? LP_CMD_WR : LP_CMD_RD;
            if (w_tx_ok) begin
               w_frame_send = 1'b1;
               w_idx_nxt    = '0;
               w_state_nxt  = S_TX_ADDR;
            end
         end
         S_TX_ADDR: begin
            w_frame_byte = f_enc(w_addr_nib);
            if (w_tx_ok) begin
               w_frame_send = 1'b1;
               if (r_idx == 3'd3) begin
                  w_idx_nxt = '0;
                  if (r_we) begin
                     w_state_nxt = S_TX_DATA;
                  end else begin
                     w_state_nxt = S_WAIT_RESP;
                     w_cnt_clr   = 1'b1;
                  end
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end
         end
         S_TX_DATA: begin
            w_frame_byte = f_enc(w_data_nib);
            if (w_tx_ok) begin
               w_frame_send = 1'b1;
               if (r_idx == 3'd1) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = S_WAIT_RESP;
                  w_cnt_clr   = 1'b1;
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end
         end
         S_WAIT_RESP: begin
            if (w_rx_proto) begin
               if (r_we) begin
                  w_state_nxt = S_FINISH;
                  w_fin_err   = (i_rx_dat != LP_ACK);
               end else if (w_dec[4]) begin
                  w_load_hi   = 1'b1;
                  w_state_nxt = S_RESP_LO;
               end else begin
                  w_state_nxt = S_FINISH;
                  w_fin_err   = 1'b1;
               end
            end else if (w_timeout) begin
               w_state_nxt = S_FINISH;
               w_fin_err   = 1'b1;
            end
         end
         S_RESP_LO: begin
            if (w_rx_proto) begin
               w_state_nxt = S_FINISH;
               if (w_dec[4]) w_load_lo = 1'b1;
               else          w_fin_err = 1'b1;
            end else if (w_timeout) begin
               w_state_nxt = S_FINISH;
               w_fin_err   = 1'b1;
            end
         end
         S_FINISH: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   assign w_fin = (w_state_nxt == S_FINISH) && (r_state != S_FINISH);

   // stream bytes only go out between frames, never inside one
   assign w_stream_send = r_sfull & w_tx_ok &
                          ((r_state == S_IDLE) || (r_state == S_WAIT_RESP) || (r_state == S_RESP_LO));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_rdata     <= '0;
         r_sbuf      <= '0;
         r_sfull     <= 1'b0;
         r_tx_start  <= 1'b0;
         r_tx_dat    <= '0;
         r_srx_dat   <= '0;
         r_srx_valid <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_tx_start <= 1'b0;
         r_idx      <= w_idx_nxt;

         if (r_state == S_IDLE && i_req) begin
            r_we    <= i_we;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
         end
         if (r_state == S_FINISH) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
         end

         if (w_cnt_clr)
            r_cnt <= '0;
         else if ((r_state == S_WAIT_RESP || r_state == S_RESP_LO) && !w_timeout)
            r_cnt <= r_cnt + CNT_W'(1);

         if (w_fin)     r_err          <= w_fin_err;
         if (w_load_hi) r_rdata[7:4]   <= w_dec[3:0];
         if (w_load_lo) r_rdata[3:0]   <= w_dec[3:0];

         if (w_frame_send) begin
            r_tx_start <= 1'b1;
            r_tx_dat   <= w_frame_byte;
         end else if (w_stream_send) begin
            r_tx_start <= 1'b1;
            r_tx_dat   <= {1'b0, r_sbuf[6:0]};
         end

         if (w_stream_send) begin
            r_sfull <= 1'b0;
         end else if (i_stream_push && !r_sfull) begin
            r_sbuf  <= i_stream_dat;
            r_sfull <= 1'b1;
         end

         r_srx_valid <= w_rx_stream;
         if (w_rx_stream) r_srx_dat <= i_rx_dat;
      end
   end

   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_err          = r_err;
   assign o_rdata        = r_rdata;
   assign o_stream_ready = ~r_sfull;
   assign o_stream_valid = r_srx_valid;
   assign o_stream_dat   = r_srx_dat;
   assign o_tx_start     = r_tx_start;
   assign o_tx_dat       = r_tx_dat;

endmodule

// File: tb/tb_uart_host_bridge.sv
// Bench for uart_host_bridge: vector table (fixed + random) against a string-based frame/reply model,
// plus hand sequences for stream interleaving and mid-frame reset.
module tb_uart_host_bridge;

   localparam int TO = 100;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_req = 1'b0, i_we = 1'b0;
   logic [15:0] i_addr = '0;
   logic [7:0]  i_wdata = '0;
   logic        o_busy, o_done, o_err;
   logic [7:0]  o_rdata;
   logic        i_stream_push = 1'b0;
   logic [7:0]  i_stream_dat = '0;
   logic        o_stream_ready, o_stream_valid;
   logic [7:0]  o_stream_dat;
   logic        o_tx_start;
   logic [7:0]  o_tx_dat;
   logic        i_tx_ready = 1'b1;
   logic        i_rx_pulse = 1'b0;
   logic [7:0]  i_rx_dat = '0;

   uart_host_bridge #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .i_clk(clk), .i_reset(i_reset),
      .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
      .i_stream_push(i_stream_push), .i_stream_dat(i_stream_dat),
      .o_stream_ready(o_stream_ready), .o_stream_valid(o_stream_valid), .o_stream_dat(o_stream_dat),
      .o_tx_start(o_tx_start), .o_tx_dat(o_tx_dat), .i_tx_ready(i_tx_ready),
      .i_rx_pulse(i_rx_pulse), .i_rx_dat(i_rx_dat)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        we;
      bit [15:0] addr;
      bit [7:0]  wdata;
      bit [7:0]  r0;
      bit [7:0]  r1;
      bit        to;
      bit        xreq;
      bit        exp_err;
      bit [7:0]  exp_rdata;
   } vec_t;

   int total = 0, bad = 0;
   int cyc = 0;
   logic [7:0] q_wire[$];
   logic [7:0] q_srx[$];
   int n_done = 0, done_cyc = 0, last_tx_cyc = 0, last_rx_cyc = 0;
   logic done_err, done_busy;
   logic [7:0] done_rdata;
   int gap = 0;

   always @(posedge clk) cyc++;

   // wire/stream/done monitor plus a uart_tx stand-in that is busy for a few cycles per byte
   always @(negedge clk) begin
      if (o_tx_start) begin
         q_wire.push_back(o_tx_dat);
         last_tx_cyc = cyc;
      end
      if (o_stream_valid) q_srx.push_back(o_stream_dat);
      if (o_done) begin
         n_done++;
         done_cyc   = cyc;
         done_err   = o_err;
         done_rdata = o_rdata;
         done_busy  = o_busy;
      end
      if (o_tx_start) gap = 4;
      else if (gap > 0) gap--;
      i_tx_ready = (gap == 0);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // reference: frame is the command letter followed by the hex text of the fields, bit7 set
   task automatic build_frame(input vec_t v, output logic [7:0] f [7], output int n);
      string s;
      s = v.we ? $sformatf("%04h%02h", v.addr, v.wdata) : $sformatf("%04h", v.addr);
      for (int i = 0; i < 7; i++) f[i] = 8'h00;
      f[0] = v.we ? 8'hD7 : 8'hD2;
      for (int i = 0; i < s.len(); i++) f[i+1] = s[i] | 8'h80;
      n = s.len() + 1;
   endtask

   function automatic bit dec(input logic [7:0] b, output logic [3:0] nib);
      string hs;
      hs = "0123456789abcdefABCDEF";
      nib = 4'h0;
      if (!b[7]) return 1'b0;
      for (int i = 0; i < 22; i++)
         if (hs[i] == {1'b0, b[6:0]}) begin
            nib = (i < 16) ? 4'(i) : 4'(i - 6);
            return 1'b1;
         end
      return 1'b0;
   endfunction

   task automatic model_reply(input vec_t v, output bit err, output logic [7:0] rd, output int nused);
      logic [3:0] h, l;
      bit okh, okl;
      rd = 8'h00;
      if (v.to) begin err = 1; nused = 0; end
      else if (v.we) begin err = (v.r0 != 8'hCB); nused = 1; end
      else begin
         okh = dec(v.r0, h);
         if (!okh) begin err = 1; nused = 1; end
         else begin
            okl = dec(v.r1, l);
            nused = 2; err = !okl; rd = {h, l};
         end
      end
   endtask

   function automatic logic [7:0] hex_char(input logic [3:0] n, input bit upper);
      string lo, up;
      lo = "0123456789abcdef";
      up = "0123456789ABCDEF";
      return (upper ? up[n] : lo[n]) | 8'h80;
   endfunction

   function automatic logic [7:0] rand_reply_char();
      logic [7:0] b;
      logic [3:0] d;
      if ($urandom_range(0, 4) == 0) begin
         do b = 8'h80 | 8'($urandom); while (dec(b, d));
         return b;
      end
      return hex_char(4'($urandom), 1'($urandom));
   endfunction

   task automatic rx_byte(input logic [7:0] b);
      @(posedge clk); #1;
      i_rx_pulse = 1'b1; i_rx_dat = b; last_rx_cyc = cyc;
      @(posedge clk); #1;
      i_rx_pulse = 1'b0;
   endtask

   task automatic issue_req(input bit we, input logic [15:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      i_req = 1'b1; i_we = we; i_addr = a; i_wdata = d;
      @(posedge clk); #1;
      i_req = 1'b0; i_addr = 16'($urandom); i_wdata = 8'($urandom);
   endtask

   task automatic wait_wire(input int n, input string nm);
      for (int k = 0; k < 400 && q_wire.size() < n; k++) @(negedge clk);
      chk(nm, q_wire.size(), n);
   endtask

   task automatic wait_done(input int n0, input int lim);
      for (int k = 0; k < lim && n_done == n0; k++) @(negedge clk);
      chk("done_seen", n_done - n0, 1);
   endtask

   task automatic do_txn(input vec_t v);
      logic [7:0] f [7];
      int n, n0, nu;
      bit e;
      logic [7:0] rd;
      build_frame(v, f, n);
      model_reply(v, e, rd, nu);
      q_wire.delete();
      n0 = n_done;
      for (int k = 0; k < 50 && o_busy; k++) @(negedge clk);
      issue_req(v.we, v.addr, v.wdata);
      wait_wire(n, "frame_len");
      for (int i = 0; i < n && i < q_wire.size(); i++) chk($sformatf("frame_byte%0d", i), q_wire[i], f[i]);
      if (v.xreq) issue_req(~v.we, ~v.addr, 8'h00);
      if (nu >= 1) begin repeat (3) @(posedge clk); rx_byte(v.r0); end
      if (nu >= 2) begin repeat (3) @(posedge clk); rx_byte(v.r1); end
      wait_done(n0, 300);
      chk("done_err", done_err, v.exp_err);
      if (!v.we && !v.exp_err) chk("done_rdata", done_rdata, v.exp_rdata);
      chk("busy_at_done", done_busy, 0);
      if (v.to) chk("timeout_latency", done_cyc - last_tx_cyc, TO);
      else      chk("reply_latency", done_cyc - last_rx_cyc, 2);
      repeat (20) @(negedge clk);
      chk("single_done", n_done - n0, 1);
      chk("no_extra_bytes", q_wire.size(), n);
   endtask

   vec_t tv[$];

   initial begin
      vec_t v;
      bit e;
      logic [7:0] rd;
      int nu, n0;
      logic [7:0] f [7];
      int n;

      tv.push_back(vec_t'{1'b1, 16'h12A4, 8'h5F, 8'hCB, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00});
      tv.push_back(vec_t'{1'b0, 16'h00FF, 8'h00, 8'hB3, 8'hC1, 1'b0, 1'b0, 1'b0, 8'h3A});
      tv.push_back(vec_t'{1'b0, 16'h5A5A, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00});
      tv.push_back(vec_t'{1'b0, 16'h0000, 8'h00, 8'hE6, 8'hC6, 1'b0, 1'b0, 1'b0, 8'hFF});
      tv.push_back(vec_t'{1'b0, 16'hFFFF, 8'h00, 8'hA0, 8'hB0, 1'b0, 1'b1, 1'b1, 8'h00});
      tv.push_back(vec_t'{1'b1, 16'hBEEF, 8'h00, 8'hD2, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00});
      tv.push_back(vec_t'{1'b0, 16'h9A0B, 8'h00, 8'hB9, 8'hB0, 1'b0, 1'b0, 1'b0, 8'h90});
      tv.push_back(vec_t'{1'b0, 16'h1234, 8'h00, 8'hB1, 8'hE7, 1'b0, 1'b0, 1'b1, 8'h00});
      for (int i = 0; i < 12; i++) begin
         v.we = 1'($urandom); v.addr = 16'($urandom); v.wdata = 8'($urandom);
         v.to = 1'b0; v.xreq = 1'b0;
         if (v.we) begin
            if ($urandom_range(0, 3) == 0) begin
               do v.r0 = 8'h80 | 8'($urandom); while (v.r0 == 8'hCB);
            end else v.r0 = 8'hCB;
            v.r1 = 8'h00;
         end else begin
            v.r0 = rand_reply_char();
            v.r1 = rand_reply_char();
         end
         model_reply(v, e, rd, nu);
         v.exp_err = e; v.exp_rdata = rd;
         tv.push_back(v);
      end

      #1;
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_err", o_err, 0);
      chk("rst_rdata", o_rdata, 0);
      chk("rst_sready", o_stream_ready, 1);
      chk("rst_svalid", o_stream_valid, 0);
      chk("rst_txstart", o_tx_start, 0);
      chk("rst_txdat", o_tx_dat, 0);
      repeat (3) @(posedge clk);
      #1 i_reset = 1'b0;
      repeat (3) @(posedge clk);

      foreach (tv[i]) do_txn(tv[i]);

      // stream: bit7 forced low on send, rx stream in idle, push mid-frame waits for frame end
      q_wire.delete(); q_srx.delete();
      @(posedge clk); #1; i_stream_push = 1'b1; i_stream_dat = 8'hF3;
      @(posedge clk); #1; i_stream_push = 1'b0;
      wait_wire(1, "stream_tx_len");
      if (q_wire.size() > 0) chk("stream_tx_byte", q_wire[0], 8'h73);
      rx_byte(8'h7E);
      repeat (2) @(negedge clk);
      chk("stream_rx_cnt", q_srx.size(), 1);
      if (q_srx.size() > 0) chk("stream_rx_dat", q_srx[0], 8'h7E);

      v = vec_t'{1'b1, 16'h12A4, 8'h5F, 8'hCB, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
      build_frame(v, f, n);
      q_wire.delete(); q_srx.delete();
      n0 = n_done;
      issue_req(1'b1, v.addr, v.wdata);
      wait_wire(2, "mid_frame_len");
      @(posedge clk); #1; i_stream_push = 1'b1; i_stream_dat = 8'h41;
      @(posedge clk); #1; i_stream_push = 1'b0;
      chk("sready_after_push", o_stream_ready, 0);
      wait_wire(8, "frame_plus_stream_len");
      for (int i = 0; i < n && i < q_wire.size(); i++) chk($sformatf("sframe_byte%0d", i), q_wire[i], f[i]);
      if (q_wire.size() > 7) chk("stream_after_frame", q_wire[7], 8'h41);
      chk("sready_after_send", o_stream_ready, 1);
      rx_byte(8'h55);
      repeat (2) @(negedge clk);
      chk("stream_rx_wait_cnt", q_srx.size(), 1);
      if (q_srx.size() > 0) chk("stream_rx_wait_dat", q_srx[0], 8'h55);
      chk("busy_during_wait", o_busy, 1);
      repeat (2) @(posedge clk);
      rx_byte(8'hCB);
      wait_done(n0, 100);
      chk("stream_txn_err", done_err, 0);

      // reset after the third frame byte abandons the transaction
      q_wire.delete();
      n0 = n_done;
      issue_req(1'b1, 16'h3C3C, 8'hA5);
      wait_wire(3, "pre_reset_len");
      #2 i_reset = 1'b1;
      #1;
      chk("mid_rst_busy", o_busy, 0);
      chk("mid_rst_done", o_done, 0);
      chk("mid_rst_err", o_err, 0);
      chk("mid_rst_rdata", o_rdata, 0);
      chk("mid_rst_sready", o_stream_ready, 1);
      chk("mid_rst_svalid", o_stream_valid, 0);
      chk("mid_rst_sdat", o_stream_dat, 0);
      chk("mid_rst_txstart", o_tx_start, 0);
      chk("mid_rst_txdat", o_tx_dat, 0);
      repeat (2) @(posedge clk);
      #1 i_reset = 1'b0;
      repeat (50) @(negedge clk);
      chk("no_done_after_reset", n_done - n0, 0);
      do_txn(vec_t'{1'b1, 16'hC0DE, 8'h7B, 8'hCB, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "global timeout");
   end

endmodule
